// File: rtl/vram_arbiter_pkg.sv
// Shared types and sizes for the VGA character RAM arbiter.
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t BURST = 2'd1;
    localparam arb_state_t DRAIN = 2'd2;

endpackage

// File: rtl/vram_arbiter_sp.sv
// Single-port synchronous character RAM: one access per cycle, registered read, no reset.
module vram_sp
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Shares the character RAM port between CPU MMIO accesses and per-line VGA burst fetches,
// giving the CPU the port once it has been denied MAX_WAIT consecutive cycles.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int COLS     = 80,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_base,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [7:0]        vga_col,
    output logic              line_done,
    output logic              line_late
);

    localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(COLS - 1);
    localparam logic [WW-1:0] W_MAX  = WW'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              late_q, late_d;
    logic              vga_rvalid_q, line_done_q, cpu_rvalid_q;
    logic [7:0]        vga_col_q;

    logic              cpu_win, issue, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        cpu_win  = cpu_req && ((state_q != BURST) || (wait_q == W_MAX));
        cpu_ack  = reset && cpu_win;
        // A restart cycle issues nothing, so no cell of the aborted line is fetched after it.
        issue    = reset && (state_q == BURST) && !cpu_ack && !line_start;
        ram_we   = cpu_ack && cpu_we;
        ram_addr = cpu_ack ? cpu_addr : base_q + ADDR_W'(k_q);

        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        late_d  = late_q;
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    state_d = BURST;
                    base_d  = line_base;
                    k_d     = '0;
                end
            end
            BURST: begin
                if (line_start) begin
                    base_d = line_base;
                    k_d    = '0;
                    late_d = 1'b1;
                end else if (issue) begin
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d = line_start ? BURST : IDLE;
                if (line_start) begin
                    base_d = line_base;
                    k_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!cpu_req || cpu_ack) begin
            wait_d = '0;
        end else if (wait_q == W_MAX) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            wait_q       <= '0;
            late_q       <= 1'b0;
            vga_rvalid_q <= 1'b0;
            vga_col_q    <= '0;
            line_done_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wait_q       <= wait_d;
            late_q       <= late_d;
            vga_rvalid_q <= issue;
            vga_col_q    <= issue ? 8'(k_q) : vga_col_q;
            line_done_q  <= issue && (k_q == K_LAST);
            cpu_rvalid_q <= cpu_ack && !cpu_we;
        end
    end

    always_ff @(posedge clock) begin
        base_q <= base_d;
    end

    vram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (cpu_wdata),
        .rdata_o (ram_rdata)
    );

    // The shared read register is steered to whichever requester owns the returning data.
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : '0;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rvalid_q ? ram_rdata : '0;
    assign vga_col    = vga_col_q;
    assign line_done  = line_done_q;
    assign line_late  = late_q;

endmodule
